// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter sharing one slave, with a one-cycle IDLE gap between grants.
// Fixed priority (master 0) by default; define WB_ARBITER_ROUND_ROBIN_EN for round-robin.
module wb_arbiter #(
    parameter int ADR_WIDTH = 16,
    parameter int DAT_WIDTH = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 m0_stb_i,
    input  logic                 m0_we_i,
    input  logic [ADR_WIDTH-1:0] m0_adr_i,
    input  logic [DAT_WIDTH-1:0] m0_dat_i,
    output logic [DAT_WIDTH-1:0] m0_dat_o,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,

    input  logic                 m1_stb_i,
    input  logic                 m1_we_i,
    input  logic [ADR_WIDTH-1:0] m1_adr_i,
    input  logic [DAT_WIDTH-1:0] m1_dat_i,
    output logic [DAT_WIDTH-1:0] m1_dat_o,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,

    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [ADR_WIDTH-1:0] s_adr_o,
    output logic [DAT_WIDTH-1:0] s_dat_o,
    input  logic [DAT_WIDTH-1:0] s_dat_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,

    output logic [1:0]           gnt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_gnt_q, last_gnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (m0_stb_i && m1_stb_i) begin
`ifdef WB_ARBITER_ROUND_ROBIN_EN
                    // Contested request goes to whoever did not hold the bus last.
                    state_d = last_gnt_q ? GRANT0 : GRANT1;
`else
                    state_d = GRANT0;
`endif
                end else if (m0_stb_i) begin
                    state_d = GRANT0;
                end else if (m1_stb_i) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (!m0_stb_i) begin
                    state_d    = IDLE;
                    last_gnt_d = 1'b0;
                end
            end
            GRANT1: begin
                if (!m1_stb_i) begin
                    state_d    = IDLE;
                    last_gnt_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus mux: everything is zero unless a grant is active.
    always_comb begin
        gnt_o    = 2'b00;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            GRANT0: begin
                gnt_o    = 2'b01;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i;
            end
            GRANT1: begin
                gnt_o    = 2'b10;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random two-master traffic against a
// grant-owner reference model and a small ROM slave (errors on write to address 0).
module tb_wb_arbiter;

    localparam int AW = 16;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stb [2];
    logic          we  [2];
    logic [AW-1:0] adr [2];
    logic [DW-1:0] wdat[2];

    logic [DW-1:0] m0_dat_o, m1_dat_o;
    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic          s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o, s_dat_i;
    logic          s_ack_i, s_err_i;
    logic [1:0]    gnt_o;

    logic stall = 1'b0;
    logic both  = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int mown     = -1;
    int mlast    = 1;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        if (a == 16'h0008) return 64'h0280800000000e60;
        return {a, ~a, 32'hA5A5_0000 ^ {16'h0, a}};
    endfunction

    assign s_dat_i = rom(s_adr_o);
    assign s_ack_i = s_stb_o && !stall && (both || !(s_we_o && s_adr_o == '0));
    assign s_err_i = s_stb_o && !stall && (both || (s_we_o && s_adr_o == '0));

    wb_arbiter #(.ADR_WIDTH(AW), .DAT_WIDTH(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .gnt_o(gnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        else n_pass++;
    endtask

    // Reference: who owns the bus after this edge, from the inputs present at the edge.
    task automatic tick();
        if (rst) begin
            mown  = -1;
            mlast = 1;
        end else if (mown < 0) begin
            if (stb[0] && stb[1]) begin
`ifdef WB_ARBITER_ROUND_ROBIN_EN
                mown = (mlast == 0) ? 1 : 0;
`else
                mown = 0;
`endif
            end else if (stb[0]) mown = 0;
            else if (stb[1]) mown = 1;
        end else if (!stb[mown]) begin
            mlast = mown;
            mown  = -1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all();
        logic [1:0]    eg;
        logic          es, ew, ea, ee;
        logic [AW-1:0] ead;
        logic [DW-1:0] ed, rd;
        #2;
        eg = 2'b00; es = 1'b0; ew = 1'b0; ead = '0; ed = '0;
        if (mown >= 0) begin
            eg  = (mown == 0) ? 2'b01 : 2'b10;
            es  = stb[mown];
            ew  = we[mown];
            ead = adr[mown];
            ed  = wdat[mown];
        end
        ea = es && !stall && (both || !(ew && ead == '0));
        ee = es && !stall && (both || (ew && ead == '0));
        rd = rom(ead);
        chk("gnt", 64'(gnt_o), 64'(eg));
        chk("s_stb", 64'(s_stb_o), 64'(es));
        chk("s_we", 64'(s_we_o), 64'(ew));
        chk("s_adr", 64'(s_adr_o), 64'(ead));
        chk("s_dat", s_dat_o, ed);
        chk("m0_ack", 64'(m0_ack_o), 64'(mown == 0 && ea));
        chk("m0_err", 64'(m0_err_o), 64'(mown == 0 && ee));
        chk("m0_dat", m0_dat_o, (mown == 0) ? rd : 64'h0);
        chk("m1_ack", 64'(m1_ack_o), 64'(mown == 1 && ea));
        chk("m1_err", 64'(m1_err_o), 64'(mown == 1 && ee));
        chk("m1_dat", m1_dat_o, (mown == 1) ? rd : 64'h0);
    endtask

    task automatic set_m(input int n, input logic s, input logic w, input logic [AW-1:0] a);
        stb[n]  = s;
        we[n]   = w;
        adr[n]  = a;
        wdat[n] = {$urandom, $urandom};
    endtask

    initial begin
        int g;
        logic [1:0] eo;
        for (int n = 0; n < 2; n++) set_m(n, 1'b0, 1'b0, '0);

        // Reset state
        rst = 1'b1;
        tick(); tick();
        check_all();
        chk("rst_gnt", 64'(gnt_o), 64'h0);
        rst = 1'b0;
        check_all();

        // Read on ROM from m0
        set_m(0, 1'b1, 1'b0, 16'h0008);
        check_all();
        chk("rd_pre_stb", 64'(s_stb_o), 64'h0);
        tick(); check_all();
        chk("rd_adr", 64'(s_adr_o), 64'h0008);
        chk("rd_ack", 64'(m0_ack_o), 64'h1);
        chk("rd_dat", m0_dat_o, 64'h0280800000000e60);
        chk("rd_m1ack", 64'(m1_ack_o), 64'h0);
        stb[0] = 1'b0; check_all();
        tick(); check_all();

        // Write error from m1
        set_m(1, 1'b1, 1'b1, 16'h0000);
        tick(); check_all();
        chk("we_err", 64'(m1_err_o), 64'h1);
        chk("we_ack", 64'(m1_ack_o), 64'h0);
        stb[1] = 1'b0; check_all();
        tick(); check_all();
        chk("we_idle_gnt", 64'(gnt_o), 64'h0);

        // Simultaneous ack+err passes through untouched
        both = 1'b1;
        set_m(0, 1'b1, 1'b0, 16'h0004);
        tick(); check_all();
        chk("both_ae", {62'h0, m0_ack_o, m0_err_o}, 64'h3);
        stb[0] = 1'b0; check_all();
        tick(); check_all();
        both = 1'b0;

        // Reset mid-transfer, then contested request goes to m0
        stall = 1'b1;
        set_m(0, 1'b1, 1'b0, 16'h0004);
        tick(); check_all();
        chk("rm_gnt0", 64'(gnt_o), 64'h1);
        rst = 1'b1;
        tick(); rst = 1'b0;
        set_m(1, 1'b1, 1'b0, 16'h0010);
        check_all();
        chk("rm_gnt_after", 64'(gnt_o), 64'h0);
        chk("rm_stb_after", 64'(s_stb_o), 64'h0);
        tick(); check_all();
        chk("rm_first", 64'(gnt_o), 64'h1);
        stall = 1'b0; check_all();
        stb[0] = 1'b0; check_all();
        tick(); check_all();
        tick(); check_all();
        chk("rm_then_m1", 64'(gnt_o), 64'h2);

        // Abort by m1 before ack, then contested request goes to m0
        stall = 1'b1; check_all();
        stb[1] = 1'b0; check_all();
        tick(); check_all();
        chk("ab_idle", 64'(gnt_o), 64'h0);
        stall = 1'b0;
        set_m(0, 1'b1, 1'b0, 16'h0002);
        set_m(1, 1'b1, 1'b0, 16'h0003);
        check_all();
        tick(); check_all();
        chk("ab_next", 64'(gnt_o), 64'h1);
        stb[0] = 1'b0; stb[1] = 1'b0; check_all();
        tick(); check_all();

        // Back-to-back contention: each winner drops after ack and re-requests
        set_m(0, 1'b1, 1'b0, 16'h0008);
        set_m(1, 1'b1, 1'b0, 16'h0005);
        check_all();
        for (int k = 0; k < 4; k++) begin
            tick(); check_all();
`ifdef WB_ARBITER_ROUND_ROBIN_EN
            eo = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            eo = 2'b01;
`endif
            chk("order", 64'(gnt_o), 64'(eo));
            g = (gnt_o == 2'b10) ? 1 : 0;
            stb[g] = 1'b0; check_all();
            tick(); check_all();
            chk("gap", 64'(s_stb_o), 64'h0);
            if (k < 3) begin
                stb[g] = 1'b1; check_all();
            end
        end
        tick(); check_all();
`ifdef WB_ARBITER_ROUND_ROBIN_EN
        chk("order_end", 64'(gnt_o), 64'h1);
`else
        chk("order_end", 64'(gnt_o), 64'h2);
`endif
        stb[0] = 1'b0; stb[1] = 1'b0; check_all();
        tick(); check_all();

        // Random traffic against the owner model
        for (int c = 0; c < 600; c++) begin
            tick();
            rst   = ($urandom % 60 == 0);
            stall = ($urandom % 4 == 0);
            if ($urandom % 10 == 0) both = ~both;
            for (int n = 0; n < 2; n++) begin
                logic got;
                got = (n == 0) ? (m0_ack_o || m0_err_o) : (m1_ack_o || m1_err_o);
                if (stb[n]) begin
                    if ((got && $urandom % 2 == 0) || $urandom % 12 == 0) stb[n] = 1'b0;
                end else if ($urandom % 3 == 0) begin
                    case ($urandom % 3)
                        0:       set_m(n, 1'b1, 1'($urandom), 16'h0000);
                        1:       set_m(n, 1'b1, 1'($urandom), 16'h0008);
                        default: set_m(n, 1'b1, 1'($urandom), AW'($urandom % 16));
                    endcase
                end
            end
            check_all();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
